// File: rtl/uart_cfg_if.sv
// AXI-Stream byte ports of the configurable UART: TX word sink and RX word source.
`timescale 1ns/1ps
interface uart_cfg_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] input_axis_tdata;
  logic                  input_axis_tvalid;
  logic                  input_axis_tready;
  logic [DATA_WIDTH-1:0] output_axis_tdata;
  logic                  output_axis_tvalid;
  logic                  output_axis_tready;

  // Fabric side: produces TX words, consumes RX words.
  modport master (
    output input_axis_tdata, input_axis_tvalid, output_axis_tready,
    input  input_axis_tready, output_axis_tdata, output_axis_tvalid
  );

  // UART side.
  modport slave (
    input  input_axis_tdata, input_axis_tvalid, output_axis_tready,
    output input_axis_tready, output_axis_tdata, output_axis_tvalid
  );
endinterface

// File: rtl/uart_cfg.sv
// Full-duplex UART, generic data width, runtime parity / stop bits, parity error and break detection.
`timescale 1ns/1ps
module uart_cfg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PS_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_cfg_if.slave           axis,
  input  logic                rxd,
  output logic                txd,
  output logic                tx_busy,
  output logic                rx_busy,
  output logic                rx_overrun_error,
  output logic                rx_frame_error,
  output logic                rx_parity_error,
  output logic                rx_break,
  input  logic [PS_WIDTH-1:0] prescale,
  input  logic [1:0]          parity_mode,
  input  logic                stop_bits
);
  localparam int unsigned CW = PS_WIDTH + 3;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [PS_WIDTH-1:0]   ps_eff_c;
  logic [CW-1:0]         bit_time_c, half_time_c;
  logic                  par_en_c, par_odd_c;

  tx_state_t             tx_state;
  logic [CW-1:0]         tx_cnt, tx_bit_time;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [BW-1:0]         tx_idx;
  logic                  tx_par_en, tx_par_bit, tx_stop2, tx_stop_last, tx_ready;

  rx_state_t             rx_state;
  logic                  rx_s1, rx_s2;
  logic [CW-1:0]         rx_cnt, rx_bit_time;
  logic [DATA_WIDTH-1:0] rx_sh, out_tdata;
  logic [BW-1:0]         rx_idx;
  logic                  rx_par_en, rx_par_odd, rx_par_err, out_tvalid;

  // Current configuration decoded into bit timing and parity controls.
  always_comb begin
    ps_eff_c    = (prescale == '0) ? PS_WIDTH'(1) : prescale;
    bit_time_c  = {ps_eff_c, 3'b000};
    half_time_c = {1'b0, ps_eff_c, 2'b00};
    par_en_c    = (parity_mode == 2'd1) || (parity_mode == 2'd2);
    par_odd_c   = (parity_mode == 2'd2);
  end

  assign axis.input_axis_tready  = tx_ready;
  assign axis.output_axis_tdata  = out_tdata;
  assign axis.output_axis_tvalid = out_tvalid;

  // TX frame sequencer; every bit is held for one full bit time.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      txd          <= 1'b1;
      tx_ready     <= 1'b0;
      tx_busy      <= 1'b0;
      tx_cnt       <= '0;
      tx_bit_time  <= '0;
      tx_sh        <= '0;
      tx_idx       <= '0;
      tx_par_en    <= 1'b0;
      tx_par_bit   <= 1'b0;
      tx_stop2     <= 1'b0;
      tx_stop_last <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          txd <= 1'b1;
          if (tx_ready && axis.input_axis_tvalid) begin
            tx_ready    <= 1'b0;
            tx_busy     <= 1'b1;
            txd         <= 1'b0;
            tx_sh       <= axis.input_axis_tdata;
            tx_bit_time <= bit_time_c;
            tx_cnt      <= bit_time_c - CW'(1);
            tx_par_en   <= par_en_c;
            tx_par_bit  <= (^axis.input_axis_tdata) ^ par_odd_c;
            tx_stop2    <= stop_bits;
            tx_state    <= TX_START;
          end else begin
            tx_ready <= 1'b1;
          end
        end
        default: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
          end else begin
            tx_cnt <= tx_bit_time - CW'(1);
            case (tx_state)
              TX_START: begin
                txd      <= tx_sh[0];
                tx_sh    <= tx_sh >> 1;
                tx_idx   <= '0;
                tx_state <= TX_DATA;
              end
              TX_DATA: begin
                if (tx_idx == LAST_BIT) begin
                  tx_stop_last <= ~tx_stop2;
                  if (tx_par_en) begin
                    txd      <= tx_par_bit;
                    tx_state <= TX_PARITY;
                  end else begin
                    txd      <= 1'b1;
                    tx_state <= TX_STOP;
                  end
                end else begin
                  txd    <= tx_sh[0];
                  tx_sh  <= tx_sh >> 1;
                  tx_idx <= tx_idx + BW'(1);
                end
              end
              TX_PARITY: begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end
              TX_STOP: begin
                if (tx_stop_last) begin
                  tx_state <= TX_IDLE;
                  tx_busy  <= 1'b0;
                  tx_ready <= 1'b1;
                end else begin
                  tx_stop_last <= 1'b1;
                end
              end
              default: tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // RX synchroniser, mid-bit sampler, error classification and output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1            <= 1'b1;
      rx_s2            <= 1'b1;
      rx_state         <= RX_IDLE;
      rx_busy          <= 1'b0;
      rx_cnt           <= '0;
      rx_bit_time      <= '0;
      rx_sh            <= '0;
      rx_idx           <= '0;
      rx_par_en        <= 1'b0;
      rx_par_odd       <= 1'b0;
      rx_par_err       <= 1'b0;
      out_tdata        <= '0;
      out_tvalid       <= 1'b0;
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
      rx_parity_error  <= 1'b0;
      rx_break         <= 1'b0;
    end else begin
      rx_s1            <= rxd;
      rx_s2            <= rx_s1;
      rx_overrun_error <= 1'b0;
      rx_frame_error   <= 1'b0;
      rx_parity_error  <= 1'b0;
      rx_break         <= 1'b0;
      if (out_tvalid && axis.output_axis_tready) out_tvalid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_state    <= RX_START;
            rx_busy     <= 1'b1;
            rx_bit_time <= bit_time_c;
            rx_cnt      <= half_time_c - CW'(1);
            rx_par_en   <= par_en_c;
            rx_par_odd  <= par_odd_c;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s2) begin
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CW'(1);
          end else begin
            rx_cnt <= rx_bit_time - CW'(1);
            case (rx_state)
              RX_START: begin
                if (rx_s2) begin
                  rx_state <= RX_IDLE;
                  rx_busy  <= 1'b0;
                end else begin
                  rx_idx     <= '0;
                  rx_par_err <= 1'b0;
                  rx_state   <= RX_DATA;
                end
              end
              RX_DATA: begin
                rx_sh <= {rx_s2, rx_sh[DATA_WIDTH-1:1]};
                if (rx_idx == LAST_BIT) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                else                    rx_idx   <= rx_idx + BW'(1);
              end
              RX_PARITY: begin
                rx_par_err <= rx_s2 != ((^rx_sh) ^ rx_par_odd);
                rx_state   <= RX_STOP;
              end
              RX_STOP: begin
                if (rx_s2) begin
                  rx_state <= RX_IDLE;
                  rx_busy  <= 1'b0;
                  if (rx_par_err) begin
                    rx_parity_error <= 1'b1;
                  end else if (out_tvalid && !axis.output_axis_tready) begin
                    rx_overrun_error <= 1'b1;
                  end else begin
                    out_tdata  <= rx_sh;
                    out_tvalid <= 1'b1;
                  end
                end else begin
                  // Line low at the stop bit: hold off until it returns high.
                  rx_state <= RX_WAIT_HIGH;
                  if (rx_sh == '0) begin
                    rx_break <= 1'b1;
                  end else begin
                    rx_frame_error  <= 1'b1;
                    rx_parity_error <= rx_par_err;
                  end
                end
              end
              default: rx_state <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cfg.sv
// Randomised self-checking bench for uart_cfg: loopback, directly driven RX frames, 9-bit reset case.
`timescale 1ns/1ps
module tb_uart_cfg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A: 8 data bits ----------------
  logic        rst_a = 1'b1, loop_a = 1'b1, drv_rxd_a = 1'b1;
  logic        rxd_a, txd_a, tx_busy_a, rx_busy_a, ovr_a, ferr_a, perr_a, brk_a;
  logic [15:0] ps_a = 16'd2;
  logic [1:0]  pm_a = 2'd0;
  logic        sb_a = 1'b0;
  uart_cfg_if #(.DATA_WIDTH(8)) if_a();
  assign rxd_a = loop_a ? txd_a : drv_rxd_a;

  uart_cfg #(.DATA_WIDTH(8), .PS_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .axis(if_a), .rxd(rxd_a), .txd(txd_a),
    .tx_busy(tx_busy_a), .rx_busy(rx_busy_a), .rx_overrun_error(ovr_a),
    .rx_frame_error(ferr_a), .rx_parity_error(perr_a), .rx_break(brk_a),
    .prescale(ps_a), .parity_mode(pm_a), .stop_bits(sb_a)
  );

  // ---------------- instance B: 9 data bits, loopback ----------------
  logic        rst_b = 1'b1;
  logic        txd_b, tx_busy_b, rx_busy_b, ovr_b, ferr_b, perr_b, brk_b;
  logic [15:0] ps_b = 16'd1;
  logic [1:0]  pm_b = 2'd0;
  logic        sb_b = 1'b1;
  uart_cfg_if #(.DATA_WIDTH(9)) if_b();

  uart_cfg #(.DATA_WIDTH(9), .PS_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst_b), .axis(if_b), .rxd(txd_b), .txd(txd_b),
    .tx_busy(tx_busy_b), .rx_busy(rx_busy_b), .rx_overrun_error(ovr_b),
    .rx_frame_error(ferr_b), .rx_parity_error(perr_b), .rx_break(brk_b),
    .prescale(ps_b), .parity_mode(pm_b), .stop_bits(sb_b)
  );

  // RX monitors: count pulses and collect accepted words, sampled mid-cycle.
  int a_perr = 0, a_ferr = 0, a_brk = 0, a_ovr = 0;
  int b_ev = 0;
  logic [8:0] a_got[$];
  logic [8:0] b_got[$];
  always @(negedge clk) begin
    #1;
    if (!rst_a) begin
      a_perr += int'(perr_a);
      a_ferr += int'(ferr_a);
      a_brk  += int'(brk_a);
      a_ovr  += int'(ovr_a);
      if (if_a.output_axis_tvalid && if_a.output_axis_tready) a_got.push_back(9'(if_a.output_axis_tdata));
    end
    if (!rst_b) begin
      b_ev += int'(perr_b) + int'(ferr_b) + int'(brk_b) + int'(ovr_b);
      if (if_b.output_axis_tvalid && if_b.output_axis_tready) b_got.push_back(if_b.output_axis_tdata);
    end
  end

  // Reference frame: bit i is the i-th bit on the line (start, data LSB first, parity, stops, idle).
  function automatic logic [15:0] frame_vec(input logic [8:0] d, input int dw, input int pm);
    logic [15:0] v;
    int ones;
    v    = '1;
    v[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < dw; i++) begin
      v[1 + i] = d[i];
      ones += int'(d[i]);
    end
    if (pm == 1) v[1 + dw] = 1'((ones % 2));
    if (pm == 2) v[1 + dw] = 1'((1 - ones % 2));
    return v;
  endfunction

  function automatic int frame_len(input int dw, input int pm, input int sb);
    return 1 + dw + ((pm == 1 || pm == 2) ? 1 : 0) + 1 + sb;
  endfunction

  function automatic int bit_time(input int ps);
    return (ps == 0) ? 8 : 8 * ps;
  endfunction

  int s_perr, s_ferr, s_brk, s_ovr, s_got;
  task automatic a_snap();
    s_perr = a_perr; s_ferr = a_ferr; s_brk = a_brk; s_ovr = a_ovr; s_got = a_got.size();
  endtask

  task automatic a_expect(input string tag, input int nw, input logic [7:0] w,
                          input int pe, input int fe, input int bk, input int ov);
    check({tag, "_nword"}, 32'(a_got.size() - s_got), 32'(nw));
    if (nw > 0 && a_got.size() > s_got) check({tag, "_word"}, 32'(a_got[s_got]), 32'(w));
    check({tag, "_perr"}, 32'(a_perr - s_perr), 32'(pe));
    check({tag, "_ferr"}, 32'(a_ferr - s_ferr), 32'(fe));
    check({tag, "_brk"},  32'(a_brk - s_brk),   32'(bk));
    check({tag, "_ovr"},  32'(a_ovr - s_ovr),   32'(ov));
  endtask

  // Push one word into TX A and record the line for the whole busy period.
  task automatic a_send(input logic [7:0] d, output int len, output int bad, output logic [15:0] cap);
    logic [15:0] v;
    int bt, guard;
    bt  = bit_time(int'(ps_a));
    v   = frame_vec(9'(d), 8, int'(pm_a));
    len = 0; bad = 0; cap = '1; guard = 0;
    if_a.input_axis_tdata  = d;
    if_a.input_axis_tvalid = 1'b1;
    while (!if_a.input_axis_tready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("a_accept_in_time", 32'(guard < 1000), 32'd1);
    @(negedge clk);
    if_a.input_axis_tvalid = 1'b0;
    while (tx_busy_a && len < 2000) begin
      if (len / bt < 16) begin
        if (txd_a !== v[len / bt]) bad++;
        if (len % bt == bt / 2) cap[len / bt] = txd_a;
      end
      len++;
      @(negedge clk);
    end
  endtask

  task automatic a_wait_rx();
    int guard;
    guard = 0;
    repeat (3) @(negedge clk);
    while (rx_busy_a && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("a_rx_idle_in_time", 32'(guard < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic a_drive(input logic [15:0] v, input int n, input int bt);
    for (int k = 0; k < n * bt; k++) begin
      drv_rxd_a = v[k / bt];
      @(negedge clk);
    end
    drv_rxd_a = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, bad, guard, bt, kind;
    logic [15:0] cap, v;
    logic [7:0] d;
    if_a.input_axis_tvalid = 1'b0; if_a.input_axis_tdata = '0; if_a.output_axis_tready = 1'b1;
    if_b.input_axis_tvalid = 1'b0; if_b.input_axis_tdata = '0; if_b.output_axis_tready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_txd", 32'(txd_a), 32'd1);
    check("rst_tready", 32'(if_a.input_axis_tready), 32'd0);
    check("rst_tvalid", 32'(if_a.output_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(if_a.output_axis_tdata), 32'd0);
    check("rst_busy", 32'({tx_busy_a, rx_busy_a}), 32'd0);
    check("rst_flags", 32'({ovr_a, ferr_a, perr_a, brk_a}), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("tready_after_rst", 32'(if_a.input_axis_tready), 32'd1);

    // 8N1 at prescale 2, loopback 0x55
    ps_a = 16'd2; pm_a = 2'd0; sb_a = 1'b0; a_snap();
    a_send(8'h55, len, bad, cap); a_wait_rx();
    check("t1_len", 32'(len), 32'd160);
    check("t1_shape", 32'(bad), 32'd0);
    a_expect("t1", 1, 8'h55, 0, 0, 0, 0);

    // Even then odd parity on 0x07
    pm_a = 2'd1; a_snap();
    a_send(8'h07, len, bad, cap); a_wait_rx();
    check("t2_even_bit", 32'(cap[9]), 32'd1);
    a_expect("t2e", 1, 8'h07, 0, 0, 0, 0);
    pm_a = 2'd2; a_snap();
    a_send(8'h07, len, bad, cap); a_wait_rx();
    check("t2_odd_bit", 32'(cap[9]), 32'd0);
    a_expect("t2o", 1, 8'h07, 0, 0, 0, 0);

    // Random loopback frames
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom); ps_a = 16'($urandom_range(0, 3));
      pm_a = 2'($urandom_range(0, 3)); sb_a = 1'($urandom_range(0, 1));
      a_snap();
      a_send(d, len, bad, cap); a_wait_rx();
      check("rnd_len", 32'(len), 32'(frame_len(8, int'(pm_a), int'(sb_a)) * bit_time(int'(ps_a))));
      check("rnd_shape", 32'(bad), 32'd0);
      a_expect("rnd", 1, d, 0, 0, 0, 0);
    end

    // Short glitch on rxd is rejected at the start-bit sample
    loop_a = 1'b0; ps_a = 16'd2; pm_a = 2'd0; sb_a = 1'b0; a_snap();
    drv_rxd_a = 1'b0; repeat (3) @(negedge clk); drv_rxd_a = 1'b1;
    repeat (40) @(negedge clk);
    a_expect("glitch", 0, 8'h00, 0, 0, 0, 0);

    // 0xA5 even parity with the parity bit inverted
    pm_a = 2'd1; a_snap();
    v = frame_vec(9'h0A5, 8, 1); v[9] = ~v[9];
    a_drive(v, 11, 16); a_wait_rx();
    a_expect("t3", 0, 8'h00, 1, 0, 0, 0);
    check("t3_tvalid", 32'(if_a.output_axis_tvalid), 32'd0);

    // Random directly driven frames: clean, parity flipped, or stop bit low
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); ps_a = 16'($urandom_range(1, 2));
      pm_a = 2'($urandom_range(1, 2)); sb_a = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 2));
      bt = bit_time(int'(ps_a));
      v = frame_vec(9'(d), 8, int'(pm_a));
      if (kind == 1) v[9] = ~v[9];
      if (kind == 2) v[10] = 1'b0;
      a_snap();
      a_drive(v, frame_len(8, int'(pm_a), int'(sb_a)), bt); a_wait_rx();
      if (kind == 0)      a_expect("rx_clean", 1, d, 0, 0, 0, 0);
      else if (kind == 1) a_expect("rx_perr", 0, 8'h00, 1, 0, 0, 0);
      else if (d == 8'h00) a_expect("rx_brk0", 0, 8'h00, 0, 0, 1, 0);
      else                a_expect("rx_ferr", 0, 8'h00, 0, 1, 0, 0);
    end

    // Overrun: consumer stalled across two frames
    loop_a = 1'b1; ps_a = 16'd1; pm_a = 2'd0; sb_a = 1'b0;
    if_a.output_axis_tready = 1'b0; a_snap();
    a_send(8'h11, len, bad, cap); a_wait_rx();
    a_send(8'h22, len, bad, cap); a_wait_rx();
    check("t4_tvalid", 32'(if_a.output_axis_tvalid), 32'd1);
    check("t4_tdata", 32'(if_a.output_axis_tdata), 32'h11);
    a_expect("t4", 0, 8'h00, 0, 0, 0, 1);
    if_a.output_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_tvalid_clr", 32'(if_a.output_axis_tvalid), 32'd0);
    a_expect("t4_drain", 1, 8'h11, 0, 0, 0, 1);

    // Break: line low for 20 bit times, then a normal 0x3C frame
    loop_a = 1'b0; ps_a = 16'd1; a_snap();
    drv_rxd_a = 1'b0; repeat (160) @(negedge clk); drv_rxd_a = 1'b1;
    repeat (20) @(negedge clk);
    a_expect("t5_break", 0, 8'h00, 0, 0, 1, 0);
    check("t5_tvalid", 32'(if_a.output_axis_tvalid), 32'd0);
    check("t5_rx_idle", 32'(rx_busy_a), 32'd0);
    a_snap();
    a_drive(frame_vec(9'h03C, 8, 0), 10, 8); a_wait_rx();
    a_expect("t5_after", 1, 8'h3C, 0, 0, 0, 0);

    // 9-bit data, two stop bits, back-to-back 0x1FF, reset mid second frame
    if_b.input_axis_tdata = 9'h1FF; if_b.input_axis_tvalid = 1'b1; guard = 0;
    while (!if_b.input_axis_tready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("t6_accept_in_time", 32'(guard < 100), 32'd1);
    @(negedge clk);
    len = 0;
    while (tx_busy_b && len < 1000) begin
      len++;
      @(negedge clk);
    end
    check("t6_len", 32'(len), 32'(frame_len(9, 0, 1) * 8));
    check("t6_b2b_ready", 32'(if_b.input_axis_tready), 32'd1);
    @(negedge clk);
    if_b.input_axis_tvalid = 1'b0;
    check("t6_second_start", 32'({tx_busy_b, txd_b}), 32'b10);
    repeat (40) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("t6_rst_txd", 32'(txd_b), 32'd1);
    check("t6_rst_busy", 32'({tx_busy_b, rx_busy_b}), 32'd0);
    check("t6_rst_tready", 32'(if_b.input_axis_tready), 32'd0);
    rst_b = 1'b0;
    @(negedge clk);
    check("t6_tready_after", 32'(if_b.input_axis_tready), 32'd1);
    repeat (150) @(negedge clk);
    check("t6_txd_idle", 32'(txd_b), 32'd1);
    check("t6_nword", 32'(b_got.size()), 32'd1);
    if (b_got.size() > 0) check("t6_word", 32'(b_got[0]), 32'h1FF);
    check("t6_events", 32'(b_ev), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
